// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
// -----------------------------------------------------------------------------
// LIFO stack of DEPTH words of WIDTH bits held in a register array. Each cycle
// one command is accepted, chosen by priority:
//     rst > tos > (push & pop) > pop > push
// Read results (tos, pop, replace) are registered and appear on resStk one
// clock after the accepting edge, with a single-cycle resValid strobe.
// Between strobes resStk holds its last value.
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   push      in   push dataIn onto the stack
//   pop       in   remove and return the top entry
//   tos       in   return the top entry without removing it
//   clrErr    in   clear the sticky overflow/underflow flags
//   dataIn    in   [WIDTH-1:0] push data
//   resStk    out  [WIDTH-1:0] registered read result
//   resValid  out  one-cycle strobe, resStk updated by the last edge
//   count     out  [CW-1:0] number of occupied entries, 0..DEPTH
//   empty     out  count == 0
//   full      out  count == DEPTH
//   overflow  out  sticky, a push was rejected on a full stack
//   underflow out  sticky, a pop or tos was rejected on an empty stack
// -----------------------------------------------------------------------------
module param_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             clrErr,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] resStk,
    output logic             resValid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    // Index width of the storage array; count needs one more bit to hold DEPTH.
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_TOS  = 3'd1,
        CMD_REPL = 3'd2,
        CMD_POP  = 3'd3,
        CMD_PUSH = 3'd4
    } cmd_e;

    // State
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] res_stk_r;
    logic             res_valid_r;
    logic             overflow_r;
    logic             underflow_r;

    // Next-state / decode
    cmd_e             cmd_s;
    logic             empty_s;
    logic             full_s;
    logic [AW-1:0]    top_idx_s;
    logic [WIDTH-1:0] top_data_s;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] res_stk_nxt_s;
    logic             res_valid_nxt_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;

    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == CW'(DEPTH));
    // On an empty stack this wraps to DEPTH-1; the value is never consumed then.
    assign top_idx_s  = AW'(count_r - CW'(1));
    assign top_data_s = mem_r[top_idx_s];

    // Resolve the simultaneous request lines into a single command.
    always_comb begin
        cmd_s = CMD_IDLE;
        if (tos) begin
            cmd_s = CMD_TOS;
        end else if (push && pop) begin
            cmd_s = CMD_REPL;
        end else if (pop) begin
            cmd_s = CMD_POP;
        end else if (push) begin
            cmd_s = CMD_PUSH;
        end else begin
            cmd_s = CMD_IDLE;
        end
    end

    // Compute next count, read result, array write and error events.
    always_comb begin
        count_nxt_s     = count_r;
        res_stk_nxt_s   = res_stk_r;
        res_valid_nxt_s = 1'b0;
        ovf_set_s       = 1'b0;
        unf_set_s       = 1'b0;
        wr_en_s         = 1'b0;
        wr_idx_s        = count_r[AW-1:0];
        case (cmd_s)
            CMD_TOS: begin
                if (!empty_s) begin
                    res_stk_nxt_s   = top_data_s;
                    res_valid_nxt_s = 1'b1;
                end else begin
                    unf_set_s = 1'b1;
                end
            end
            CMD_REPL: begin
                if (!empty_s) begin
                    // Swap the top entry: old value out, dataIn in, same depth.
                    res_stk_nxt_s   = top_data_s;
                    res_valid_nxt_s = 1'b1;
                    wr_en_s         = 1'b1;
                    wr_idx_s        = top_idx_s;
                end else begin
                    // Nothing to return, so this degrades to a plain push.
                    wr_en_s     = 1'b1;
                    wr_idx_s    = {AW{1'b0}};
                    count_nxt_s = CW'(1);
                end
            end
            CMD_POP: begin
                if (!empty_s) begin
                    res_stk_nxt_s   = top_data_s;
                    res_valid_nxt_s = 1'b1;
                    count_nxt_s     = CW'(count_r - CW'(1));
                end else begin
                    unf_set_s = 1'b1;
                end
            end
            CMD_PUSH: begin
                if (!full_s) begin
                    // count < DEPTH here, so its low bits address the free slot.
                    wr_en_s     = 1'b1;
                    wr_idx_s    = count_r[AW-1:0];
                    count_nxt_s = CW'(count_r + CW'(1));
                end else begin
                    ovf_set_s = 1'b1;
                end
            end
            CMD_IDLE: begin
                count_nxt_s = count_r;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Control and result registers; reset wins over every command.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {CW{1'b0}};
            res_stk_r   <= {WIDTH{1'b0}};
            res_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            res_stk_r   <= res_stk_nxt_s;
            res_valid_r <= res_valid_nxt_s;
            // A new error in the same cycle as clrErr leaves the flag set.
            overflow_r  <= ovf_set_s | (overflow_r  & ~clrErr);
            underflow_r <= unf_set_s | (underflow_r & ~clrErr);
        end
    end

    // Storage array; not cleared by reset, but a reset cycle never writes it.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[wr_idx_s] <= dataIn;
        end else begin
            mem_r[wr_idx_s] <= mem_r[wr_idx_s];
        end
    end

    assign resStk    = res_stk_r;
    assign resValid  = res_valid_r;
    assign count     = count_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_param_stack.sv
// -----------------------------------------------------------------------------
// tb_param_stack
// -----------------------------------------------------------------------------
// Directed bench for param_stack at WIDTH=8, DEPTH=4. A table of
// {inputs, expected outputs} records is applied one clock per entry and every
// output is checked 1 time unit after the rising edge. Two hand-written
// sequences follow for repeated overflow and draining past empty.
// -----------------------------------------------------------------------------
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic             clrErr;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] resStk;
    logic             resValid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int n_cmp;
    int n_bad;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .clrErr    (clrErr),
        .dataIn    (dataIn),
        .resStk    (resStk),
        .resValid  (resValid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             push;
        logic             pop;
        logic             tos;
        logic             clr;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] e_res;
        logic             e_valid;
        logic [CW-1:0]    e_count;
        logic             e_ovf;
        logic             e_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic pu, input logic po,
                                input logic t, input logic c,
                                input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] er, input logic ev,
                                input logic [CW-1:0] ec, input logic eo,
                                input logic eu);
        vec_t v;
        v.rst = r; v.push = pu; v.pop = po; v.tos = t; v.clr = c; v.din = d;
        v.e_res = er; v.e_valid = ev; v.e_count = ec; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    // Drive one cycle of inputs, clock it, and sample 1 unit after the edge.
    task automatic apply(input logic r, input logic pu, input logic po,
                         input logic t, input logic c, input logic [WIDTH-1:0] d);
        rst = r; push = pu; pop = po; tos = t; clrErr = c; dataIn = d;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected record; empty/full follow count.
    task automatic check(input string name, input logic [WIDTH-1:0] er,
                         input logic ev, input logic [CW-1:0] ec,
                         input logic eo, input logic eu);
        logic [15:0] act;
        logic [15:0] exp;
        logic        ee;
        logic        ef;
        ee  = (ec == 3'd0);
        ef  = (ec == 3'd4);
        act = {resStk, resValid, count, empty, full, overflow, underflow};
        exp = {er, ev, ec, ee, ef, eo, eu};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got res=%h v=%b cnt=%0d e=%b f=%b o=%b u=%b, want res=%h v=%b cnt=%0d e=%b f=%b o=%b u=%b",
                     name, resStk, resValid, count, empty, full, overflow, underflow,
                     er, ev, ec, ee, ef, eo, eu);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] model [$];
        logic [WIDTH-1:0] last;
        logic             ovf;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; clrErr = 1'b0;
        dataIn = 8'h00;

        //                 rst  push pop  tos  clr  din     res    v     cnt   o     u
        // reset, then errors on an empty stack
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b0));
        // fill, overflow, pop
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h11, 8'h00,1'b0,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h22, 8'h00,1'b0,3'd2,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h33, 8'h00,1'b0,3'd3,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h44, 8'h00,1'b0,3'd4,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h55, 8'h00,1'b0,3'd4,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h44,1'b1,3'd3,1'b1,1'b0));
        // all three high: tos wins, then idle holds resStk
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b0,8'hEE, 8'h33,1'b1,3'd3,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h33,1'b0,3'd3,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h33,1'b1,3'd2,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h22,1'b1,3'd1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h11,1'b1,3'd0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h11,1'b0,3'd0,1'b0,1'b0));
        // peek twice then pop
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'hA5, 8'h11,1'b0,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hA5,1'b1,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hA5,1'b1,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'hA5,1'b1,3'd0,1'b0,1'b0));
        // replace
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h01, 8'hA5,1'b0,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h02, 8'hA5,1'b0,3'd2,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,8'h7E, 8'h02,1'b1,3'd2,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h7E,1'b1,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h01,1'b1,3'd0,1'b0,1'b0));
        // push&pop on empty acts as push
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,8'h9C, 8'h01,1'b0,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h9C,1'b1,3'd0,1'b0,1'b0));
        // full stack, reset with concurrent push
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h01, 8'h9C,1'b0,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h02, 8'h9C,1'b0,3'd2,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h03, 8'h9C,1'b0,3'd3,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h04, 8'h9C,1'b0,3'd4,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,8'hAA, 8'h00,1'b0,3'd0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b1));
        // clrErr together with a fresh error leaves the flag set
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b1,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b0));
        // reset right after a pop drops the strobe
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h5A, 8'h00,1'b0,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h5A,1'b1,3'd0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,3'd0,1'b0,1'b0));
        // replace is legal when full and never overflows
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'hC1, 8'h00,1'b0,3'd1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'hC2, 8'h00,1'b0,3'd2,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'hC3, 8'h00,1'b0,3'd3,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'hC4, 8'h00,1'b0,3'd4,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,8'h77, 8'hC4,1'b1,3'd4,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,8'h88, 8'hC4,1'b0,3'd4,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'h77,1'b1,3'd3,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 8'hC3,1'b1,3'd2,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,8'h00, 8'hC2,1'b1,3'd2,1'b0,1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].tos,
                  vecs[i].clr, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].e_res, vecs[i].e_valid,
                  vecs[i].e_count, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Hand sequence 1: reset, then push eight distinct words; the pointer
        // must stop at DEPTH and the extra pushes must only raise overflow.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("seq_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
        model.delete();
        ovf  = 1'b0;
        last = 8'h00;
        for (int k = 0; k < 8; k++) begin
            logic [WIDTH-1:0] d;
            d = 8'(8'hF0 + k * 3);
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d);
            if (model.size() < DEPTH) model.push_back(d);
            else ovf = 1'b1;
            check($sformatf("seq_push%0d", k), last, 1'b0, CW'(model.size()), ovf, 1'b0);
        end

        // Hand sequence 2: drain in LIFO order, then one pop past empty.
        for (int k = 0; k < DEPTH; k++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            last = model.pop_back();
            check($sformatf("seq_pop%0d", k), last, 1'b1, CW'(model.size()), ovf, 1'b0);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("seq_pop_empty", last, 1'b0, 3'd0, ovf, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
